// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single shared memory port.
// Each transaction walks IDLE -> GRANT (until the memory responds) -> RESP.
module mem_arbiter #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned LINE_SIZE     = 32,
  parameter int unsigned COUNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     p0_reqValid,
  input  logic [ADDRESS_WIDTH-1:0] p0_reqAddress,
  input  logic [LINE_SIZE-1:0]     p0_reqDataIn,
  input  logic                     p0_reqWen,
  output logic                     p0_respValid,
  output logic [LINE_SIZE-1:0]     p0_respDataOut,
  input  logic                     p1_reqValid,
  input  logic [ADDRESS_WIDTH-1:0] p1_reqAddress,
  input  logic [LINE_SIZE-1:0]     p1_reqDataIn,
  input  logic                     p1_reqWen,
  output logic                     p1_respValid,
  output logic [LINE_SIZE-1:0]     p1_respDataOut,
  output logic                     mem_reqValid,
  output logic [ADDRESS_WIDTH-1:0] mem_reqAddress,
  output logic [LINE_SIZE-1:0]     mem_reqDataIn,
  output logic                     mem_reqWen,
  input  logic                     mem_respValid,
  input  logic [LINE_SIZE-1:0]     mem_respDataIn,
  output logic                     busy,
  output logic                     grantId,
  output logic [COUNT_WIDTH-1:0]   p0_count,
  output logic [COUNT_WIDTH-1:0]   p1_count
);

  typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;

  state_t                   state_q;
  logic                     rr_q;
  logic                     grant_q;
  logic                     busy_q;
  logic                     mem_valid_q;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q;
  logic [LINE_SIZE-1:0]     mem_data_q;
  logic                     mem_wen_q;
  logic                     p0_resp_q;
  logic                     p1_resp_q;
  logic [LINE_SIZE-1:0]     p0_rdata_q;
  logic [LINE_SIZE-1:0]     p1_rdata_q;
  logic [COUNT_WIDTH-1:0]   p0_cnt_q;
  logic [COUNT_WIDTH-1:0]   p1_cnt_q;
  logic                     win_c;

  // A lone requester wins; on contention the round-robin pointer decides.
  always_comb begin
    win_c = p1_reqValid;
    if (p0_reqValid && p1_reqValid) begin
      win_c = rr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      grant_q     <= 1'b0;
      busy_q      <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_wen_q   <= 1'b0;
      p0_resp_q   <= 1'b0;
      p1_resp_q   <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      p0_cnt_q    <= '0;
      p1_cnt_q    <= '0;
    end else begin
      p0_resp_q <= 1'b0;
      p1_resp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (p0_reqValid || p1_reqValid) begin
            state_q     <= GRANT;
            busy_q      <= 1'b1;
            mem_valid_q <= 1'b1;
            grant_q     <= win_c;
            rr_q        <= ~win_c;
            mem_addr_q  <= win_c ? p1_reqAddress : p0_reqAddress;
            mem_data_q  <= win_c ? p1_reqDataIn  : p0_reqDataIn;
            mem_wen_q   <= win_c ? p1_reqWen     : p0_reqWen;
          end
        end
        GRANT: begin
          // Request stays up through the response cycle so the memory can clear it.
          if (mem_respValid) begin
            state_q     <= RESP;
            mem_valid_q <= 1'b0;
            if (grant_q) begin
              p1_resp_q <= 1'b1;
              p1_cnt_q  <= p1_cnt_q + COUNT_WIDTH'(1);
              if (!mem_wen_q) p1_rdata_q <= mem_respDataIn;
            end else begin
              p0_resp_q <= 1'b1;
              p0_cnt_q  <= p0_cnt_q + COUNT_WIDTH'(1);
              if (!mem_wen_q) p0_rdata_q <= mem_respDataIn;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign p0_respValid   = p0_resp_q;
  assign p1_respValid   = p1_resp_q;
  assign p0_respDataOut = p0_rdata_q;
  assign p1_respDataOut = p1_rdata_q;
  assign mem_reqValid   = mem_valid_q;
  assign mem_reqAddress = mem_addr_q;
  assign mem_reqDataIn  = mem_data_q;
  assign mem_reqWen     = mem_wen_q;
  assign busy           = busy_q;
  assign grantId        = grant_q;
  assign p0_count       = p0_cnt_q;
  assign p1_count       = p1_cnt_q;

endmodule
